// File: rtl/alu_op_decoder_pkg.sv
// Shared definitions for the ALU opcode decoder: instruction field layout, the
// operation mnemonic enum, the decoded-op payload and the decode function.
package alu_op_decoder_pkg;

  localparam int unsigned InstrW = 9;
  localparam int unsigned FieldW = 3;
  localparam int unsigned OpMsb  = 8;
  localparam int unsigned OpLsb  = 6;
  localparam int unsigned RdMsb  = 5;
  localparam int unsigned RdLsb  = 3;
  localparam int unsigned RsMsb  = 2;
  localparam int unsigned RsLsb  = 0;

  localparam logic [FieldW-1:0] kOpIllegal = 3'b111;

  // Encoding equals the instruction opcode field; 3'b111 is reserved as illegal.
  typedef enum logic [FieldW-1:0] {
    ADD = 3'b000,
    LSH = 3'b001,
    RSH = 3'b010,
    XOR = 3'b011,
    AND = 3'b100,
    SUB = 3'b101,
    CLR = 3'b110
  } op_mne;

  typedef struct packed {
    op_mne             op;
    logic [FieldW-1:0] rd;
    logic [FieldW-1:0] rs;
    logic [FieldW-1:0] sh_amt;
  } decoded_op_t;

  // Low field is a source register for ALU ops, a shift amount for shifts,
  // and ignored for CLR. Illegal opcodes decode to ADD; they are never buffered.
  function automatic decoded_op_t decode_instr(logic [InstrW-1:0] instr);
    decoded_op_t d;
    logic [FieldW-1:0] opc;
    opc      = instr[OpMsb:OpLsb];
    d.op     = (opc == kOpIllegal) ? ADD : op_mne'(opc);
    d.rd     = instr[RdMsb:RdLsb];
    d.rs     = '0;
    d.sh_amt = '0;
    case (d.op)
      ADD, XOR, AND, SUB: d.rs     = instr[RsMsb:RsLsb];
      LSH, RSH:           d.sh_amt = instr[RsMsb:RsLsb];
      default:            ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer, generic over the payload type.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_valid_i/in_ready_o   : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i : downstream handshake, out_data_o payload
// in_ready_o is registered and depends only on occupancy, so no combinational
// path exists from out_ready_i to in_ready_o.
module decode_skid_buf #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  T       main_q, main_d;
  T       skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    push    = in_valid_i && in_ready_q;
    pop     = (state_q != StEmpty) && out_ready_i;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          main_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_d = in_data_i;
        end else if (push) begin
          skid_d  = in_data_i;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a drain can happen.
        if (pop) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;

endmodule

// File: rtl/alu_op_decoder.sv
// ALU opcode decoder: accepts 9-bit instructions from fetch, decodes them and
// hands decoded ops to the ALU through a 2-entry skid buffer.
//   Clk, Reset (sync, active-high)
//   InValid/InReady/InInstr          : fetch handshake, instruction [8:6] op
//   OutValid/OutReady/OutOp/OutRd/OutRs/OutShAmt : ALU handshake and fields
//   IllegalOp/IllegalInstr           : sticky illegal flag, first bad instr
//   IssueCount                       : completed output handshakes (wraps)
//   PerfSel/PerfCount                : per-op issue counter readout
// Build option: define DECODE_PERF_CNT_EN to instantiate per-op counters;
// otherwise PerfCount reads 0 and PerfSel is ignored.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [8:0]        InInstr,
  output logic              OutValid,
  input  logic              OutReady,
  output op_mne             OutOp,
  output logic [2:0]        OutRd,
  output logic [2:0]        OutRs,
  output logic [2:0]        OutShAmt,
  output logic              IllegalOp,
  output logic [8:0]        IllegalInstr,
  output logic [CNT_W-1:0]  IssueCount,
  input  logic [2:0]        PerfSel,
  output logic [CNT_W-1:0]  PerfCount
);

  decoded_op_t       dec, out_op;
  logic              is_illegal, in_fire, out_fire;
  logic              buf_ready, buf_valid;
  logic              illegal_q;
  logic [8:0]        illegal_instr_q;
  logic [CNT_W-1:0]  issue_q;

  assign dec        = decode_instr(InInstr);
  assign is_illegal = (InInstr[OpMsb:OpLsb] == kOpIllegal);
  assign in_fire    = InValid && buf_ready;
  assign out_fire   = buf_valid && OutReady;

  // Illegal instructions complete the input handshake but are dropped here.
  decode_skid_buf #(
    .T (decoded_op_t)
  ) u_skid (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .in_valid_i  (InValid && !is_illegal),
    .in_ready_o  (buf_ready),
    .in_data_i   (dec),
    .out_valid_o (buf_valid),
    .out_ready_i (OutReady),
    .out_data_o  (out_op)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      illegal_q       <= 1'b0;
      illegal_instr_q <= '0;
    end else if (in_fire && is_illegal) begin
      illegal_q <= 1'b1;
      if (!illegal_q) begin
        illegal_instr_q <= InInstr;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      issue_q <= '0;
    end else if (out_fire) begin
      issue_q <= issue_q + CNT_W'(1);
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q [7];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 7; i++) begin
        perf_q[i] <= '0;
      end
    end else if (out_fire) begin
      perf_q[out_op.op] <= perf_q[out_op.op] + CNT_W'(1);
    end
  end

  always_comb begin
    PerfCount = '0;
    if (PerfSel != kOpIllegal) begin
      PerfCount = perf_q[PerfSel];
    end
  end
`else
  logic unused_perf_sel;
  assign unused_perf_sel = ^PerfSel;
  assign PerfCount       = '0;
`endif

  assign InReady      = buf_ready;
  assign OutValid     = buf_valid;
  assign OutOp        = out_op.op;
  assign OutRd        = out_op.rd;
  assign OutRs        = out_op.rs;
  assign OutShAmt     = out_op.sh_amt;
  assign IllegalOp    = illegal_q;
  assign IllegalInstr = illegal_instr_q;
  assign IssueCount   = issue_q;

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Producer side of the ALU opcode interface: accepts 9-bit instructions over a valid/ready handshake, decodes each into an op_mne operation plus operand fields, and presents the result to the ALU stage over a second valid/ready handshake.
- Sits between instruction fetch and the ALU.
- Contains a 2-entry skid buffer, so a stalled ALU never forces fetch to drop an instruction.
- Keeps an illegal-opcode sticky flag and an issued-op counter.

Parameters:
- CNT_W, 16, width of the issue counter and of the per-op performance counters.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  fetch presents an instruction
- InReady  out  1  decoder can accept an instruction this cycle
- InInstr  in  9  [8:6] opcode, [5:3] rd, [2:0] rs or shift amount
- OutValid  out  1  decoded op available
- OutReady  in  1  ALU accepts the decoded op this cycle
- OutOp  out  op_mne  decoded operation
- OutRd  out  3  destination register index
- OutRs  out  3  source register index (0 for shift ops and CLR)
- OutShAmt  out  3  shift amount (0 unless LSH/RSH)
- IllegalOp  out  1  sticky: an opcode 3'b111 was accepted
- IllegalInstr  out  9  first illegal instruction captured
- IssueCount  out  CNT_W  number of completed output handshakes
- PerfSel  in  3  op_mne index selecting a performance counter
- PerfCount  out  CNT_W  selected per-op count

Behaviour:
- Reset: clear both buffer entries (OutValid=0). InReady=1, OutOp=ADD, OutRd/OutRs/OutShAmt=0, IllegalOp=0, IllegalInstr=0, IssueCount=0, all perf counters 0. Reset mid-transfer discards any buffered ops.
- Transfer rules:
  - Input transfer when InValid&&InReady.
  - Output transfer when OutValid&&OutReady.
  - OutValid and the Out* fields must stay stable while OutValid&&!OutReady.
- State machine, on buffer occupancy:
  - EMPTY -> ONE on input transfer.
  - ONE -> EMPTY on output transfer with no input transfer.
  - ONE stays ONE on simultaneous input and output transfer: main register reloads from the input.
  - ONE -> TWO on input transfer with no output transfer: the new op goes to the skid register.
  - TWO -> ONE on output transfer: skid moves to main. InReady=0 in TWO, so no input transfer can occur.
- InReady is registered: 1 in EMPTY and ONE, 0 in TWO. It depends only on state, never combinationally on OutReady.
- Latency: an accepted instruction is visible on Out* exactly 1 cycle later when the buffer was EMPTY. Full throughput is one op per cycle while OutReady=1.
- Decode is done before the buffer, so buffers hold decoded fields:
  - ADD, XOR, AND, SUB: Rs=[2:0], ShAmt=0.
  - LSH, RSH: ShAmt=[2:0], Rs=0.
  - CLR: Rs=0, ShAmt=0.
  - Rd=[5:3] for all ops.
- Illegal opcode 3'b111:
  - Accepted (consumes the input transfer) but never enters the buffer.
  - Sets IllegalOp. Captures InInstr into IllegalInstr only if IllegalOp was 0.
  - Cleared only by Reset.
- IssueCount increments by 1 per output transfer and wraps from all-ones to 0.

Optional Feature:
- DECODE_PERF_CNT_EN defined: seven CNT_W counters, one per op_mne value.
  - The counter for OutOp increments on each output transfer and wraps.
  - PerfCount = counter[PerfSel], combinational. PerfSel=3'b111 returns 0.
- DECODE_PERF_CNT_EN undefined: no counters are instantiated, PerfCount is tied to 0, and PerfSel is ignored. The port list is identical in both builds.

Decomposition:
- Add to package Definitions:
  - instruction field widths and bit positions;
  - kOpIllegal = 3'b111;
  - a packed struct decoded_op_t {op_mne op; logic [2:0] rd, rs, sh_amt;}.
- One sub-module, decode_skid_buf: a 2-entry valid/ready buffer parameterised on the payload type, holding decoded_op_t.

Test Plan:
- Streaming: OutReady=1 held, feed 9'b000_001_010 then 9'b001_011_101 on consecutive cycles -> OutOp=ADD, Rd=1, Rs=2 the cycle after; then LSH, Rd=3, ShAmt=5, Rs=0. IssueCount=2.
- Backpressure: OutReady=0, feed 3 back-to-back ops -> first two accepted, InReady drops to 0 after the second, third held by fetch. Out* stable. Raise OutReady -> all three emerge in order, no loss or duplication.
- Illegal: feed 9'b111_010_001 then 9'b111_000_000 -> IllegalOp=1, IllegalInstr=9'b111_010_001, OutValid never asserted for either, IssueCount unchanged.
- Simultaneous: buffer in ONE, InValid=1 and OutReady=1 in the same cycle -> stays ONE, new op on Out* next cycle.
- Reset mid-op: buffer in TWO, assert Reset for 1 cycle -> OutValid=0, InReady=1, IssueCount=0, IllegalOp=0 next cycle.
- Perf/wrap (with DECODE_PERF_CNT_EN): issue 3 SUB and 1 CLR, PerfSel=SUB -> PerfCount=3. Force IssueCount to all-ones and issue 1 op -> IssueCount=0.
